// File: rtl/l2_mem_pkg.sv
// Shared types and defaults for the L2 memory responder slice.
package l2_mem_pkg;

   localparam int DATA_W         = 32;
   localparam int LINE_WORDS_DEF = 4;
   localparam int LATENCY_DEF    = 4;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_WDATA  = 3'd1,
      ST_WAIT   = 3'd2,
      ST_RBURST = 3'd3,
      ST_WACK   = 3'd4
   } state_e;

endpackage

// File: rtl/l2_mem_responder_if.sv
// L1 <-> L2 request / writeback / response bundle.
// rsp_err exists only when L2_RESP_ERR_EN is defined.
interface l2_mem_responder_if #(
   parameter int ADDR_WIDTH = 32
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_we;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic                  wr_valid;
   logic                  wr_ready;
   logic [31:0]           wr_data;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [31:0]           rsp_data;
   logic                  rsp_last;
   logic                  busy;
`ifdef L2_RESP_ERR_EN
   logic                  rsp_err;
`endif

   modport master (
      output req_valid, req_we, req_addr, wr_valid, wr_data, rsp_ready,
`ifdef L2_RESP_ERR_EN
      input  rsp_err,
`endif
      input  req_ready, wr_ready, rsp_valid, rsp_data, rsp_last, busy
   );

   modport slave (
      input  req_valid, req_we, req_addr, wr_valid, wr_data, rsp_ready,
`ifdef L2_RESP_ERR_EN
      output rsp_err,
`endif
      output req_ready, wr_ready, rsp_valid, rsp_data, rsp_last, busy
   );
endinterface

// File: rtl/l2_mem_array.sv
// Single-port backing store: synchronous write, combinational read.
module l2_mem_array #(
   parameter int DEPTH_WORDS = 1024,
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 10
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/l2_mem_responder.sv
// L2 line responder: line refill bursts and line writebacks against a local store.
// Optional macro L2_RESP_ERR_EN adds rsp_err for out-of-range line requests.
module l2_mem_responder
   import l2_mem_pkg::*;
#(
   parameter int ADDR_WIDTH  = 32,
   parameter int DEPTH_WORDS = 1024,
   parameter int LINE_WORDS  = LINE_WORDS_DEF,
   parameter int LATENCY     = LATENCY_DEF
) (
   input logic               clk,
   input logic               reset,
   l2_mem_responder_if.slave bus
);

   localparam int IDX_W  = ADDR_WIDTH - 2;
   localparam int AIDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam int BEAT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
   localparam int LAT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   localparam logic [2:0] S_IDLE   = ST_IDLE;
   localparam logic [2:0] S_WDATA  = ST_WDATA;
   localparam logic [2:0] S_WAIT   = ST_WAIT;
   localparam logic [2:0] S_RBURST = ST_RBURST;
   localparam logic [2:0] S_WACK   = ST_WACK;

   logic [2:0]        state_q;
   logic [BEAT_W-1:0] beat_q;
   logic [LAT_W-1:0]  lat_q;
   logic              we_q;
   logic [IDX_W-1:0]  base_q;
   logic              err_q;

   logic [IDX_W-1:0]  req_base;
   logic [IDX_W-1:0]  word_idx;
   logic [IDX_W-1:0]  word_mod;
   logic [AIDX_W-1:0] arr_addr;
   logic              arr_we;
   logic [DATA_W-1:0] rd_data;
   logic              beat_last;
   logic              lat_done;
   logic              accept;
   logic              unused_bits;

   // Line base in words: byte offset dropped, word-in-line offset cleared.
   assign req_base  = bus.req_addr[ADDR_WIDTH-1:2] & ~IDX_W'(LINE_WORDS - 1);
   assign word_idx  = base_q + IDX_W'(beat_q);
   assign word_mod  = word_idx % IDX_W'(DEPTH_WORDS);
   assign arr_addr  = word_mod[AIDX_W-1:0];
   assign beat_last = (beat_q == BEAT_W'(LINE_WORDS - 1));
   assign lat_done  = (lat_q == LAT_W'(LATENCY - 1));
   assign accept    = (state_q == S_IDLE) && bus.req_valid;

   assign unused_bits = ^{bus.req_addr[1:0], word_mod[IDX_W-1:AIDX_W]};

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         beat_q  <= '0;
         lat_q   <= '0;
         we_q    <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.req_valid) begin
                  we_q   <= bus.req_we;
                  beat_q <= '0;
                  lat_q  <= '0;
                  if (bus.req_we)
                     state_q <= S_WDATA;
                  else
                     state_q <= (LATENCY == 0) ? S_RBURST : S_WAIT;
               end
            end
            S_WDATA: begin
               if (bus.wr_valid) begin
                  beat_q <= beat_q + BEAT_W'(1);
                  if (beat_last) state_q <= (LATENCY == 0) ? S_WACK : S_WAIT;
               end
            end
            S_WAIT: begin
               if (lat_done) begin
                  lat_q   <= '0;
                  state_q <= we_q ? S_WACK : S_RBURST;
               end else begin
                  lat_q <= lat_q + LAT_W'(1);
               end
            end
            S_RBURST: begin
               // Beat only advances on a handshake, so data holds under backpressure.
               if (bus.rsp_ready) begin
                  beat_q <= beat_q + BEAT_W'(1);
                  if (beat_last) state_q <= S_IDLE;
               end
            end
            S_WACK: begin
               if (bus.rsp_ready) state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (accept) base_q <= req_base;
   end

`ifdef L2_RESP_ERR_EN
   always_ff @(posedge clk) begin
      if (reset)
         err_q <= 1'b0;
      else if (accept)
         err_q <= (req_base >= IDX_W'(DEPTH_WORDS));
   end

   assign bus.rsp_err = err_q && ((state_q == S_RBURST) || (state_q == S_WACK));
`else
   assign err_q = 1'b0;
`endif

   assign arr_we = (state_q == S_WDATA) && bus.wr_valid && !err_q;

   l2_mem_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .DATA_W      (DATA_W),
      .ADDR_W      (AIDX_W)
   ) u_array (
      .clk   (clk),
      .we    (arr_we),
      .addr  (arr_addr),
      .wdata (bus.wr_data),
      .rdata (rd_data)
   );

   assign bus.req_ready = (state_q == S_IDLE);
   assign bus.wr_ready  = (state_q == S_WDATA);
   assign bus.rsp_valid = (state_q == S_RBURST) || (state_q == S_WACK);
   assign bus.rsp_last  = (state_q == S_WACK) || ((state_q == S_RBURST) && beat_last);
   assign bus.rsp_data  = ((state_q == S_RBURST) && !err_q) ? rd_data : '0;
   assign bus.busy      = (state_q != S_IDLE);

endmodule
